// File: rtl/gray_arb_pkg.sv
// Shared types and helpers for the Gray-code conversion arbiter: width defaults,
// the binary-to-Gray function and the round-robin winner search.
package gray_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int GRAY_MAX_WIDTH     = 64;
  localparam int RR_MAX_REQ         = 16;
  localparam int RR_IDX_W           = 4;

  // Zero-extended input keeps the MSB rule intact for any narrower width.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin_to_gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                                  input logic [RR_IDX_W-1:0]   ptr,
                                                  input int                    num_req);
    logic [RR_IDX_W-1:0] pick;
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX_REQ; i++) begin
      idx = RR_IDX_W'((int'(ptr) + i) % num_req);
      if (!found && (i < num_req) && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/binary_to_gray_converter_n_bit.sv
// Combinational N-bit binary-to-Gray converter.
module binary_to_gray_converter_n_bit
  import gray_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] bin,
  output logic [DATA_WIDTH-1:0] gray
);

  assign gray = DATA_WIDTH'(bin_to_gray(GRAY_MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_converter_arbiter.sv
// Round-robin arbiter feeding one shared binary-to-Gray converter and a single output register.
// Optional saturating stall counter port enabled by defining GRAY_ARB_STALL_CNT_EN.
module gray_converter_arbiter
  import gray_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          Clock_In,
  input  logic                          Reset_In,
  input  logic                          Enable_In,
  input  logic [NUM_REQ-1:0]            Req_Valid_In,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
  output logic [NUM_REQ-1:0]            Req_Ready_Out,
  output logic                          Gray_Valid_Out,
  output logic [DATA_WIDTH-1:0]         Gray_Data_Out,
  output logic [ID_WIDTH-1:0]           Gray_Id_Out,
  input  logic                          Gray_Ready_In
`ifdef GRAY_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   Stall_Count_Out
`endif
);

  logic [ID_WIDTH-1:0]   ptr_q;
  logic [ID_WIDTH-1:0]   winner_p0;
  logic [ID_WIDTH-1:0]   ptr_next_p0;
  logic [DATA_WIDTH-1:0] win_data_p0;
  logic [DATA_WIDTH-1:0] gray_p0;
  logic                  free_p0;
  logic                  load_p0;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] gray_data_p1;
  logic [ID_WIDTH-1:0]   gray_id_p1;

  // Stage p0: arbitration, winner mux and conversion
  assign free_p0     = !vld_p1 || Gray_Ready_In;
  assign load_p0     = Enable_In && free_p0 && (|Req_Valid_In) && !Reset_In;
  assign winner_p0   = ID_WIDTH'(rr_pick(RR_MAX_REQ'(Req_Valid_In), RR_IDX_W'(ptr_q), NUM_REQ));
  assign ptr_next_p0 = (winner_p0 == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner_p0 + 1'b1;

  always_comb begin
    win_data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_p0 == ID_WIDTH'(i)) win_data_p0 = Req_Data_In[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  binary_to_gray_converter_n_bit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_conv (
    .bin  (win_data_p0),
    .gray (gray_p0)
  );

  assign Req_Ready_Out = load_p0 ? (NUM_REQ'(1) << winner_p0) : '0;

  // Stage p1: output register; a load overrides the consume so back-to-back words have no bubble
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      vld_p1       <= 1'b0;
      gray_data_p1 <= '0;
      gray_id_p1   <= '0;
      ptr_q        <= '0;
    end else if (load_p0) begin
      vld_p1       <= 1'b1;
      gray_data_p1 <= gray_p0;
      gray_id_p1   <= winner_p0;
      ptr_q        <= ptr_next_p0;
    end else if (free_p0) begin
      vld_p1       <= 1'b0;
    end
  end

  assign Gray_Valid_Out = vld_p1;
  assign Gray_Data_Out  = gray_data_p1;
  assign Gray_Id_Out    = gray_id_p1;

`ifdef GRAY_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      stall_cnt_q <= '0;
    end else if (vld_p1 && !Gray_Ready_In && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign Stall_Count_Out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gray_converter_arbiter.sv
// Bench for gray_converter_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_gray_converter_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  vld;
  logic [31:0] data;
  logic [3:0]  Req_Ready_Out;
  logic        Gray_Valid_Out;
  logic [7:0]  Gray_Data_Out;
  logic [1:0]  Gray_Id_Out;
  logic        grdy;
`ifdef GRAY_ARB_STALL_CNT_EN
  logic [15:0] Stall_Count_Out;
`endif

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit         m_vld;
  logic [7:0] m_data;
  int         m_id;
  int         m_ptr;
  int         m_stall;

  gray_converter_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8)
  ) dut (
    .Clock_In       (clk),
    .Reset_In       (rst),
    .Enable_In      (en),
    .Req_Valid_In   (vld),
    .Req_Data_In    (data),
    .Req_Ready_Out  (Req_Ready_Out),
    .Gray_Valid_Out (Gray_Valid_Out),
    .Gray_Data_Out  (Gray_Data_Out),
    .Gray_Id_Out    (Gray_Id_Out),
    .Gray_Ready_In  (grdy)
`ifdef GRAY_ARB_STALL_CNT_EN
    ,
    .Stall_Count_Out(Stall_Count_Out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] gray_ref(input logic [7:0] b);
    logic [7:0] g;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) g[k] = b[7];
      else        g[k] = b[k] ^ b[k+1];
    end
    return g;
  endfunction

  function automatic int model_win();
    int idx;
    for (int i = 0; i < 4; i++) begin
      idx = (m_ptr + i) % 4;
      if (vld[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: check outputs and accept strobe against the model, then advance the model.
  task automatic cycle();
    int         w;
    bit         ld;
    logic [3:0] er;
    #1;
    ld = en && (!m_vld || grdy) && (vld != 4'b0) && !rst;
    w  = model_win();
    er = 4'b0;
    if (ld) er[w] = 1'b1;
    chk("gray_valid", Gray_Valid_Out, m_vld);
    chk("gray_data", Gray_Data_Out, m_data);
    chk("gray_id", Gray_Id_Out, m_id);
    chk("req_ready", Req_Ready_Out, er);
`ifdef GRAY_ARB_STALL_CNT_EN
    chk("stall_count", Stall_Count_Out, m_stall);
`endif
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_data = 8'h00; m_id = 0; m_ptr = 0; m_stall = 0;
    end else begin
      if (m_vld && !grdy && m_stall < 16'hFFFF) m_stall++;
      if (ld) begin
        m_data = gray_ref(data[w*8 +: 8]);
        m_id   = w;
        m_vld  = 1;
        m_ptr  = (w + 1) % 4;
      end else if (m_vld && grdy) begin
        m_vld = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] hold_d;
    rst = 1'b1; en = 1'b1; vld = 4'hF; data = 32'h0; grdy = 1'b1;
    m_vld = 0; m_data = 8'h00; m_id = 0; m_ptr = 0; m_stall = 0;
    @(posedge clk);
    @(negedge clk);

    // reset held two cycles with every requester valid
    cycle();
    cycle();
    #1;
    chk("rst_ready", Req_Ready_Out, 4'b0000);
    chk("rst_valid", Gray_Valid_Out, 1'b0);
    chk("rst_data", Gray_Data_Out, 8'h00);
    chk("rst_id", Gray_Id_Out, 2'd0);
    rst = 1'b0;
    cycle();
    chk("first_grant_id", Gray_Id_Out, 2'd0);

    // single requester
    vld = 4'b0100; data = 32'h00A5_0000;
    #1 chk("single_ready", Req_Ready_Out, 4'b0100);
    cycle();
    chk("single_data", Gray_Data_Out, 8'hF7);
    chk("single_id", Gray_Id_Out, 2'd2);
    chk("single_valid", Gray_Valid_Out, 1'b1);

    // round robin from a fresh pointer
    rst = 1'b1;
    cycle();
    rst = 1'b0; vld = 4'hF; data = 32'h3121_1101;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_id", Gray_Id_Out, 32'(k % 4));
      chk("rr_data", Gray_Data_Out, gray_ref(8'(8'h10 * (k % 4) + 1)));
      if (k == 1) chk("rr_id1_data", Gray_Data_Out, 8'h19);
    end

    // back-pressure holding the ID0 word
    hold_d = gray_ref(8'h01);
    grdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("stall_ready", Req_Ready_Out, 4'b0000);
      cycle();
      chk("stall_data", Gray_Data_Out, hold_d);
      chk("stall_id", Gray_Id_Out, 2'd0);
      chk("stall_valid", Gray_Valid_Out, 1'b1);
    end
`ifdef GRAY_ARB_STALL_CNT_EN
    chk("stall_cnt5", Stall_Count_Out, 16'd5);
`endif
    grdy = 1'b1;
    cycle();
    chk("release_id", Gray_Id_Out, 2'd1);
    chk("release_valid", Gray_Valid_Out, 1'b1);

    // enable gating: drain then resume from frozen pointer
    en = 1'b0;
    cycle();
    chk("gate_drain", Gray_Valid_Out, 1'b0);
    cycle();
    chk("gate_idle", Gray_Valid_Out, 1'b0);
    en = 1'b1;
    cycle();
    chk("gate_resume_id", Gray_Id_Out, 2'd2);

    // reset while stalled
    grdy = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_stall_valid", Gray_Valid_Out, 1'b0);
    rst = 1'b0; grdy = 1'b1;
    cycle();
    chk("rst_stall_ptr", Gray_Id_Out, 2'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 49) == 0);
      en   = ($urandom_range(0, 7) != 0);
      vld  = 4'($urandom);
      data = $urandom;
      grdy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
